ram64_arbiter: RTL and testbench
================================

Name: ram64_arbiter

Overview:
- Shares one 64x16 single-port RAM (6-bit address, 16-bit data, write-enable, write on clk rising edge, combinational read) between two requesters, A and B.
- Round-robin ownership with bounded bursts; each requester gets a req/gnt handshake and a registered read response.
- Sits between the CPU-side datapath masters (e.g. fetch and data access) and the RAM instance.

Parameters:
- MAX_BURST, 4, max consecutive accepted accesses by one owner while the other requester waits (1..15).
- AW, 6, RAM address width.
- DW, 16, RAM data width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  requester A access request
- a_we  input  1  A: 1 = write, 0 = read
- a_addr  input  AW  A address
- a_wdata  input  DW  A write data
- a_gnt  output  1  A access accepted this cycle
- a_rvalid  output  1  A read data valid (one cycle after accepted read)
- a_rdata  output  DW  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- ram_addr  output  AW  to RAM address
- ram_in  output  DW  to RAM write data
- ram_load  output  1  to RAM write enable
- ram_out  input  DW  from RAM read data (combinational)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_owner=B (so A wins the first tie), burst_cnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0. Combinational outputs are then gnt=0, ram_load=0, ram_addr=0, ram_in=0.
- Access rule: at most one access per cycle. An access is accepted when x_req && x_gnt. x_gnt is combinational from the current state and the req inputs.
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - one req → grant it;
  - both → grant the requester that is not last_owner.
- OWN_X:
  - grant X while x_req=1 and burst_cnt<MAX_BURST;
  - if X drops req, or burst_cnt==MAX_BURST with the other requesting, grant the other this same cycle (no bubble);
  - if neither requests → IDLE.
- burst_cnt:
  - reset to 1 on a change of owner or on a grant from IDLE;
  - increments per accepted access of the same owner, saturating at MAX_BURST;
  - when the other requester is idle, the owner keeps the grant indefinitely and the count stays saturated.
- Next-state register: state ← OWN_<granted> if any grant, else IDLE. last_owner updates on every grant.
- RAM drive (combinational): ram_addr/ram_in come from the granted requester; ram_load = gnt && we. With no grant: ram_addr=0, ram_in=0, ram_load=0.
- Write: RAM updates at the rising edge of the accepting cycle. No response is generated.
- Read: ram_out is sampled at the rising edge ending the accepting cycle into x_rdata. x_rvalid=1 for exactly the following cycle (latency 1). x_rdata holds its value when rvalid=0.
- Back-to-back reads give rvalid on consecutive cycles.
- Same-address write then read in the next cycle returns the new data.
- Ungranted requester must hold req/we/addr/wdata stable until granted.
- Reset mid-operation: a pending rvalid is dropped. A write accepted in the cycle rst_n falls may or may not land; the bench must not check it.
- x_gnt never asserts while x_req=0.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2), requester IDs (REQ_A=1'b0, REQ_B=1'b1), default AW/DW.
- One natural sub-module: rr_grant2. It is a combinational 2-way round-robin pick from (req, state, burst_cnt, last_owner) → grant vector.
- The top holds the registers, the RAM mux and the read-response path. The RAM itself stays a separate instance outside this block.

Test Plan:
- Reset then A only: A writes 16'hBEEF @6'd5, then reads @5 → a_gnt=1 both cycles; a_rvalid=1 the cycle after the read with a_rdata=16'hBEEF; b_gnt=0 throughout.
- Simultaneous first request: a_req=b_req=1 from IDLE after reset → A granted (last_owner=B at reset). With B also requesting throughout, A gets exactly MAX_BURST=4 grants, then B gets 4, alternating with no idle cycle.
- Owner drops mid-burst: A granted 2 cycles then a_req=0 with B waiting → b_gnt=1 in the same cycle a_req falls; B burst_cnt=1.
- Write/read collision: A writes 16'h1234 @0x3F while B waits; B then reads @0x3F → b_rdata=16'h1234; rvalid on B only.
- Address wrap/boundary: writes to @0 and @63, read both back → values correct; no grant → ram_load=0, ram_addr=0.
- Async reset mid-read: rst_n=0 in the cycle after a B read is accepted → b_rvalid=0 immediately, state=IDLE; after release, the first tie goes to A.

Source files
------------

// File: rtl/ram64_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram64_arbiter_pkg;

    localparam int unsigned DEF_AW  = 6;
    localparam int unsigned DEF_DW  = 16;
    localparam int unsigned BURST_W = 4;

    // Requester IDs double as bit indices into the grant vector.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwnA = 2'd1,
        StOwnB = 2'd2
    } state_e;

    function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt,
                                                     input logic [BURST_W-1:0] max);
        return (cnt < max) ? cnt + 1'b1 : cnt;
    endfunction

endpackage

// File: rtl/ram64_arbiter_rr_grant2.sv
// Combinational 2-way round-robin pick with bounded bursts.
module ram64_arbiter_rr_grant2
    import ram64_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic [1:0]         i_req,
    input  state_e             i_state,
    input  logic [BURST_W-1:0] i_burst_cnt,
    input  logic               i_last_owner,
    output logic [1:0]         o_gnt
);

    localparam logic [BURST_W-1:0] MaxCnt = BURST_W'(MAX_BURST);

    logic w_under;

    assign w_under = (i_burst_cnt < MaxCnt);

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_state)
            StOwnA: begin
                // Owner keeps going until its burst is spent and the other side is waiting.
                if (i_req[REQ_A] && (w_under || !i_req[REQ_B])) begin
                    o_gnt[REQ_A] = 1'b1;
                end else if (i_req[REQ_B]) begin
                    o_gnt[REQ_B] = 1'b1;
                end
            end
            StOwnB: begin
                if (i_req[REQ_B] && (w_under || !i_req[REQ_A])) begin
                    o_gnt[REQ_B] = 1'b1;
                end else if (i_req[REQ_A]) begin
                    o_gnt[REQ_A] = 1'b1;
                end
            end
            default: begin
                if (i_req[REQ_A] && i_req[REQ_B]) begin
                    if (i_last_owner == REQ_B) begin
                        o_gnt[REQ_A] = 1'b1;
                    end else begin
                        o_gnt[REQ_B] = 1'b1;
                    end
                end else begin
                    o_gnt = i_req;
                end
            end
        endcase
    end

endmodule

// File: rtl/ram64_arbiter.sv
// Shares one single-port RAM between requesters A and B; round-robin with bounded bursts
// and a registered one-cycle read response per requester.
module ram64_arbiter
    import ram64_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_in,
    output logic          ram_load,
    input  logic [DW-1:0] ram_out
);

    localparam logic [BURST_W-1:0] MaxCnt = BURST_W'(MAX_BURST);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_last_owner;
    logic               w_last_next;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_next;
    logic [1:0]         w_gnt;
    logic               w_a_rd;
    logic               w_b_rd;

    ram64_arbiter_rr_grant2 #(
        .MAX_BURST (MAX_BURST)
    ) u_rr_grant2 (
        .i_req        ({b_req, a_req}),
        .i_state      (r_state),
        .i_burst_cnt  (r_burst_cnt),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_gnt)
    );

    assign a_gnt  = w_gnt[REQ_A];
    assign b_gnt  = w_gnt[REQ_B];
    assign w_a_rd = w_gnt[REQ_A] & ~a_we;
    assign w_b_rd = w_gnt[REQ_B] & ~b_we;

    always_comb begin
        w_state_next = StIdle;
        w_last_next  = r_last_owner;
        w_burst_next = '0;
        if (w_gnt[REQ_A]) begin
            w_state_next = StOwnA;
            w_last_next  = REQ_A;
            w_burst_next = (r_state == StOwnA) ? burst_inc(r_burst_cnt, MaxCnt)
                                                : BURST_W'(1);
        end else if (w_gnt[REQ_B]) begin
            w_state_next = StOwnB;
            w_last_next  = REQ_B;
            w_burst_next = (r_state == StOwnB) ? burst_inc(r_burst_cnt, MaxCnt)
                                                : BURST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_last_owner <= REQ_B;
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_owner <= w_last_next;
            r_burst_cnt  <= w_burst_next;
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_in   = '0;
        ram_load = 1'b0;
        if (w_gnt[REQ_A]) begin
            ram_addr = a_addr;
            ram_in   = a_wdata;
            ram_load = a_we;
        end else if (w_gnt[REQ_B]) begin
            ram_addr = b_addr;
            ram_in   = b_wdata;
            ram_load = b_we;
        end
    end

    // Read data is captured from the combinational RAM output at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= w_a_rd;
            b_rvalid <= w_b_rd;
            if (w_a_rd) begin
                a_rdata <= ram_out;
            end
            if (w_b_rd) begin
                b_rdata <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Directed and random checks of ram64_arbiter against a behavioural arbiter/memory model.
module tb_ram64_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [5:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_load;
    logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
    logic [5:0]  ram_addr;

    always #5 clk = ~clk;

    ram64_arbiter #(.MAX_BURST(MB), .AW(6), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_addr (ram_addr),
        .ram_in   (ram_in),
        .ram_load (ram_load),
        .ram_out  (ram_out)
    );

    // External RAM instance the arbiter drives.
    logic [15:0] ram_mem [64];
    always @(posedge clk) if (ram_load) ram_mem[ram_addr] <= ram_in;
    assign ram_out = ram_mem[ram_addr];

    int total = 0;
    int bad   = 0;

    // Reference model: owner 0=none 1=A 2=B, run length of current owner, last owner.
    int          m_owner, m_run, m_last;
    logic [15:0] m_mem [64];
    logic        m_a_rv, m_b_rv;
    logic [15:0] m_a_rd, m_b_rd;
    int          last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_run = 0; m_last = 2;
        m_a_rv = 1'b0; m_b_rv = 1'b0; m_a_rd = '0; m_b_rd = '0;
    endtask

    function automatic int predict();
        bit own_req, oth_req;
        if (m_owner == 0) begin
            if (a_req && b_req) return (m_last == 2) ? 1 : 2;
            if (a_req) return 1;
            if (b_req) return 2;
            return 0;
        end
        own_req = (m_owner == 1) ? a_req : b_req;
        oth_req = (m_owner == 1) ? b_req : a_req;
        if (own_req && (m_run < MB || !oth_req)) return m_owner;
        if (oth_req) return 3 - m_owner;
        return 0;
    endfunction

    // One clock cycle: inputs are already applied; check, clock, update model.
    task automatic step();
        int          g;
        logic [5:0]  e_addr;
        logic [15:0] e_in;
        logic        e_load;
        #1;
        g = predict();
        e_addr = (g == 1) ? a_addr : (g == 2) ? b_addr : 6'd0;
        e_in   = (g == 1) ? a_wdata : (g == 2) ? b_wdata : 16'd0;
        e_load = (g == 1) ? a_we : (g == 2) ? b_we : 1'b0;
        chk("a_gnt", a_gnt, g == 1);
        chk("b_gnt", b_gnt, g == 2);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_in", ram_in, e_in);
        chk("ram_load", ram_load, e_load);
        chk("a_rvalid", a_rvalid, m_a_rv);
        chk("a_rdata", a_rdata, m_a_rd);
        chk("b_rvalid", b_rvalid, m_b_rv);
        chk("b_rdata", b_rdata, m_b_rd);
        @(posedge clk);
        m_a_rv = (g == 1) && !a_we;
        m_b_rv = (g == 2) && !b_we;
        if (m_a_rv) m_a_rd = m_mem[a_addr];
        if (m_b_rv) m_b_rd = m_mem[b_addr];
        if (g == 1 && a_we) m_mem[a_addr] = a_wdata;
        if (g == 2 && b_we) m_mem[b_addr] = b_wdata;
        if (g == 0) begin
            m_owner = 0; m_run = 0;
        end else begin
            m_run   = (g == m_owner) ? ((m_run < MB) ? m_run + 1 : m_run) : 1;
            m_owner = g;
            m_last  = g;
        end
        last_g = g;
        #1;
    endtask

    task automatic do_reset();
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_a_rvalid", a_rvalid, 1'b0);
        chk("rst_b_rvalid", b_rvalid, 1'b0);
        chk("rst_a_rdata", a_rdata, 16'h0);
        chk("rst_b_rdata", b_rdata, 16'h0);
        chk("rst_gnt", {a_gnt, b_gnt}, 2'b00);
        chk("rst_ram_load", ram_load, 1'b0);
        chk("rst_ram_addr", ram_addr, 6'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fill the RAM so every later read has a defined expectation.
        for (int i = 0; i < 64; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 6'(i); a_wdata = 16'($urandom);
            step();
        end

        // A only: write then read back.
        a_we = 1'b1; a_addr = 6'd5; a_wdata = 16'hBEEF;
        step();
        a_we = 1'b0;
        step();
        a_req = 1'b0;
        chk("beef_rvalid", a_rvalid, 1'b1);
        chk("beef_rdata", a_rdata, 16'hBEEF);
        step();

        // Tie from reset: A first, then bursts of MB alternating with no gap.
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
        for (int i = 0; i < 4 * MB; i++) begin
            step();
            chk("tie_seq", last_g, ((i / MB) % 2 == 0) ? 1 : 2);
        end

        // Owner drops mid-burst: B takes over in the same cycle with a fresh burst.
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        step();
        step();
        a_req = 1'b0;
        step();
        chk("drop_b", last_g, 2);
        a_req = 1'b1;
        for (int i = 0; i < MB; i++) begin
            step();
            chk("drop_seq", last_g, (i < MB - 1) ? 2 : 1);
        end

        // A writes 0x3F while B waits to read it.
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'h3F; a_wdata = 16'h1234;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
        step();
        chk("coll_a_first", last_g, 1);
        a_req = 1'b0;
        step();
        b_req = 1'b0;
        chk("coll_b_rvalid", b_rvalid, 1'b1);
        chk("coll_b_rdata", b_rdata, 16'h1234);
        chk("coll_a_rvalid", a_rvalid, 1'b0);
        step();

        // Address boundaries 0 and 63.
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'd0; b_wdata = 16'hA5A5;
        step();
        b_addr = 6'd63; b_wdata = 16'h5A5A;
        step();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd0;
        step();
        a_addr = 6'd63;
        chk("bnd_rd0", a_rdata, 16'hA5A5);
        step();
        a_req = 1'b0;
        chk("bnd_rd63", a_rdata, 16'h5A5A);
        #1;
        chk("idle_load", ram_load, 1'b0);
        chk("idle_addr", ram_addr, 6'd0);
        step();

        // Async reset right after a B read is accepted.
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd63;
        step();
        chk("pre_rst_rvalid", b_rvalid, 1'b1);
        b_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_drop_rvalid", b_rvalid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; b_req = 1'b1; b_we = 1'b0;
        step();
        chk("post_rst_tie", last_g, 1);

        // Random traffic; an ungranted request is held stable.
        for (int n = 0; n < 400; n++) begin
            if (!a_req || last_g == 1) begin
                a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom);
                a_addr = 6'($urandom); a_wdata = 16'($urandom);
            end
            if (!b_req || last_g == 2) begin
                b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom);
                b_addr = 6'($urandom); b_wdata = 16'($urandom);
            end
            step();
        end
        a_req = 1'b0; b_req = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
